// File: rtl/l1_servo_pkg.sv
// Shared types and helpers for the L1 per-beam threshold servo.
// Optional feature macro used by this slice: L1_SERVO_COARSE_STEP_EN.
package l1_servo_pkg;

    typedef enum logic [1:0] {
        STOPPED   = 2'b00,
        WAITING   = 2'b01,
        SERVICING = 2'b10,
        DRAINING  = 2'b11
    } loop_state_t;

    localparam int unsigned START_THRESH_DEFAULT = 4500;
    localparam int unsigned COARSE_FACTOR        = 8;

    // Saturating step; arguments are wide so thr+step never wraps.
    function automatic logic [63:0] sat_step(
        input logic [63:0] thr,
        input logic [63:0] step,
        input logic        up,
        input logic [63:0] lo_lim,
        input logic [63:0] hi_lim
    );
        if (up)
            return (thr + step > hi_lim) ? hi_lim : thr + step;
        else
            return (thr < lo_lim + step) ? lo_lim : thr - step;
    endfunction

endpackage

// File: rtl/l1_servo_compare.sv
// Registered compare/step stage: classifies a scaler count against target +/- delta
// and produces the saturated next threshold. Coarse step under L1_SERVO_COARSE_STEP_EN.
module l1_servo_compare
    import l1_servo_pkg::*;
#(
    parameter int unsigned THRESH_BITS  = 18,
    parameter int unsigned SCAL_BITS    = 24,
    parameter int unsigned STEP_BITS    = 12,
    parameter int unsigned THRESH_MIN   = 0,
    parameter int unsigned THRESH_MAX   = (1 << THRESH_BITS) - 1,
    parameter int unsigned COARSE_SHIFT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [SCAL_BITS-1:0]   count,
    input  logic [SCAL_BITS-1:0]   target,
    input  logic [SCAL_BITS-1:0]   delta,
    input  logic [STEP_BITS-1:0]   step,
    input  logic [THRESH_BITS-1:0] thr,
    output logic [THRESH_BITS-1:0] new_thr
);

    logic [SCAL_BITS:0]     hi;
    logic [SCAL_BITS-1:0]   lo;
    logic [63:0]            eff_step;
    logic [THRESH_BITS-1:0] nxt;
`ifdef L1_SERVO_COARSE_STEP_EN
    localparam logic [63:0] STEP_LIM = (64'd1 << THRESH_BITS) - 64'd1;
    logic [SCAL_BITS-1:0]   dist;
`endif

    always_comb begin
        hi       = {1'b0, target} + {1'b0, delta};
        lo       = (target > delta) ? target - delta : '0;
        eff_step = 64'(step);
`ifdef L1_SERVO_COARSE_STEP_EN
        dist = (count > target) ? count - target : target - count;
        if (64'(dist) > 64'(delta) * 64'(COARSE_FACTOR)) begin
            eff_step = 64'(step) << COARSE_SHIFT;
            if (eff_step > STEP_LIM)
                eff_step = STEP_LIM;
        end
`endif
        if ({1'b0, count} > hi)
            nxt = THRESH_BITS'(sat_step(64'(thr), eff_step, 1'b1, 64'(THRESH_MIN), 64'(THRESH_MAX)));
        else if (count < lo)
            nxt = THRESH_BITS'(sat_step(64'(thr), eff_step, 1'b0, 64'(THRESH_MIN), 64'(THRESH_MAX)));
        else
            nxt = thr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            new_thr <= '0;
        else if (en)
            new_thr <= nxt;
    end

endmodule

// File: rtl/l1_thresh_servo.sv
// N-beam L1 threshold servo: per period, reads each beam's scaler, steps its threshold
// and writes it to the trigger via wr/ack. Coarse step option: L1_SERVO_COARSE_STEP_EN.
module l1_thresh_servo
    import l1_servo_pkg::*;
#(
    parameter int unsigned NBEAMS       = 48,
    parameter int unsigned THRESH_BITS  = 18,
    parameter int unsigned SCAL_BITS    = 24,
    parameter int unsigned STEP_BITS    = 12,
    parameter int unsigned START_THRESH = START_THRESH_DEFAULT,
    parameter int unsigned THRESH_MIN   = 0,
    parameter int unsigned THRESH_MAX   = (1 << THRESH_BITS) - 1,
    parameter int unsigned COARSE_SHIFT = 3
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   loop_enable_i,
    input  logic                   period_tick_i,
    input  logic [SCAL_BITS-1:0]   target_rate_i,
    input  logic [SCAL_BITS-1:0]   target_delta_i,
    input  logic [STEP_BITS-1:0]   step_i,
    output logic [1:0]             loop_state_o,
    output logic                   scal_req_o,
    output logic [5:0]             scal_idx_o,
    input  logic [SCAL_BITS-1:0]   scal_dat_i,
    input  logic                   scal_valid_i,
    output logic                   thresh_wr_o,
    output logic [5:0]             thresh_idx_o,
    output logic [THRESH_BITS-1:0] thresh_dat_o,
    input  logic                   thresh_ack_i,
    output logic                   thresh_update_o,
    input  logic                   init_wr_i,
    input  logic [5:0]             init_idx_i,
    input  logic [THRESH_BITS-1:0] init_dat_i,
    input  logic [5:0]             rd_idx_i,
    output logic [THRESH_BITS-1:0] rd_dat_o,
    output logic                   overrun_o
);

    typedef enum logic [1:0] {PH_REQ, PH_CALC, PH_WR} phase_t;

    loop_state_t            state_q, state_d;
    phase_t                 phase_q, phase_d;
    logic [5:0]             beam_q;
    logic [SCAL_BITS-1:0]   cnt_q;
    logic [THRESH_BITS-1:0] thr_mem [NBEAMS];
    logic [THRESH_BITS-1:0] new_thr;
    logic                   active, beam_clr, beam_inc, latch_cnt, calc_en, store, update_d;

    assign active = (state_q == SERVICING) || (state_q == DRAINING);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= STOPPED;
            phase_q <= PH_REQ;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        beam_clr  = 1'b0;
        beam_inc  = 1'b0;
        latch_cnt = 1'b0;
        calc_en   = 1'b0;
        store     = 1'b0;
        update_d  = 1'b0;
        case (state_q)
            STOPPED: if (loop_enable_i) state_d = WAITING;
            WAITING: begin
                if (!loop_enable_i) begin
                    state_d = STOPPED;
                end else if (period_tick_i) begin
                    state_d  = SERVICING;
                    phase_d  = PH_REQ;
                    beam_clr = 1'b1;
                end
            end
            default: begin
                // Draining keeps walking the current beam's phases but stops at its ack.
                if (state_q == SERVICING && !loop_enable_i)
                    state_d = DRAINING;
                case (phase_q)
                    PH_REQ: if (scal_valid_i) begin
                        latch_cnt = 1'b1;
                        phase_d   = PH_CALC;
                    end
                    PH_CALC: begin
                        calc_en = 1'b1;
                        phase_d = PH_WR;
                    end
                    default: if (thresh_ack_i) begin
                        store   = 1'b1;
                        phase_d = PH_REQ;
                        if (state_q == DRAINING || !loop_enable_i) begin
                            state_d = STOPPED;
                        end else if (beam_q == 6'(NBEAMS - 1)) begin
                            state_d  = WAITING;
                            update_d = 1'b1;
                        end else begin
                            beam_inc = 1'b1;
                        end
                    end
                endcase
            end
        endcase
    end

    l1_servo_compare #(
        .THRESH_BITS (THRESH_BITS),
        .SCAL_BITS   (SCAL_BITS),
        .STEP_BITS   (STEP_BITS),
        .THRESH_MIN  (THRESH_MIN),
        .THRESH_MAX  (THRESH_MAX),
        .COARSE_SHIFT(COARSE_SHIFT)
    ) u_compare (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .en     (calc_en),
        .count  (cnt_q),
        .target (target_rate_i),
        .delta  (target_delta_i),
        .step   (step_i),
        .thr    (thr_mem[beam_q]),
        .new_thr(new_thr)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            beam_q          <= '0;
            cnt_q           <= '0;
            rd_dat_o        <= '0;
            overrun_o       <= 1'b0;
            thresh_update_o <= 1'b0;
            for (int unsigned i = 0; i < NBEAMS; i++)
                thr_mem[i] <= THRESH_BITS'(START_THRESH);
        end else begin
            thresh_update_o <= update_d;
            if (beam_clr)
                beam_q <= '0;
            else if (beam_inc)
                beam_q <= beam_q + 6'd1;
            if (latch_cnt)
                cnt_q <= scal_dat_i;
            if (store)
                thr_mem[beam_q] <= new_thr;
            else if (state_q == STOPPED && init_wr_i && 32'(init_idx_i) < NBEAMS)
                thr_mem[init_idx_i] <= init_dat_i;
            rd_dat_o <= (32'(rd_idx_i) < NBEAMS) ? thr_mem[rd_idx_i] : '0;
            if (period_tick_i && active)
                overrun_o <= 1'b1;
            else if (init_wr_i)
                overrun_o <= 1'b0;
        end
    end

    assign loop_state_o = state_q;
    assign scal_req_o   = active && (phase_q == PH_REQ);
    assign thresh_wr_o  = active && (phase_q == PH_WR);
    assign scal_idx_o   = beam_q;
    assign thresh_idx_o = beam_q;
    assign thresh_dat_o = new_thr;

endmodule

// File: tb/tb_l1_thresh_servo.sv
// Directed/randomized bench for l1_thresh_servo against an arithmetic threshold model.
// Honours L1_SERVO_COARSE_STEP_EN in the model when the macro is defined.
module tb_l1_thresh_servo;

    localparam int NB   = 48;
    localparam int TBW  = 18;
    localparam int SBW  = 24;
    localparam int STBW = 12;
    localparam longint unsigned TMAX = 262143;

    logic            clk = 1'b0;
    logic            rst;
    logic            loop_enable, period_tick;
    logic [SBW-1:0]  target_rate, target_delta, scal_dat;
    logic [STBW-1:0] step;
    logic [1:0]      loop_state;
    logic            scal_req, scal_valid, thresh_wr, thresh_ack, thresh_update, init_wr, overrun;
    logic [5:0]      scal_idx, thresh_idx, init_idx, rd_idx;
    logic [TBW-1:0]  thresh_dat, init_dat, rd_dat;

    int checks   = 0;
    int failures = 0;
    longint unsigned model_thr [NB];
    longint unsigned cnt_tab   [NB];
    int unsigned     ackd_tab  [NB];

    always #5 clk = ~clk;

    l1_thresh_servo dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .loop_enable_i  (loop_enable),
        .period_tick_i  (period_tick),
        .target_rate_i  (target_rate),
        .target_delta_i (target_delta),
        .step_i         (step),
        .loop_state_o   (loop_state),
        .scal_req_o     (scal_req),
        .scal_idx_o     (scal_idx),
        .scal_dat_i     (scal_dat),
        .scal_valid_i   (scal_valid),
        .thresh_wr_o    (thresh_wr),
        .thresh_idx_o   (thresh_idx),
        .thresh_dat_o   (thresh_dat),
        .thresh_ack_i   (thresh_ack),
        .thresh_update_o(thresh_update),
        .init_wr_i      (init_wr),
        .init_idx_i     (init_idx),
        .init_dat_i     (init_dat),
        .rd_idx_i       (rd_idx),
        .rd_dat_o       (rd_dat),
        .overrun_o      (overrun)
    );

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Threshold rule straight from the rate-control description.
    function automatic longint unsigned model_next(input longint unsigned thr, input longint unsigned cnt);
        longint unsigned tgt, dlt, hi, lo, eff;
        tgt = target_rate;
        dlt = target_delta;
        hi  = tgt + dlt;
        lo  = (tgt > dlt) ? tgt - dlt : 0;
        eff = step;
`ifdef L1_SERVO_COARSE_STEP_EN
        begin
            longint unsigned dist;
            dist = (cnt > tgt) ? cnt - tgt : tgt - cnt;
            if (dist > 8 * dlt) begin
                eff = longint'(step) * 8;
                if (eff > TMAX) eff = TMAX;
            end
        end
`endif
        if (cnt > hi) return (thr + eff > TMAX) ? TMAX : thr + eff;
        if (cnt < lo) return (thr < eff) ? 0 : thr - eff;
        return thr;
    endfunction

    task automatic start_pass();
        period_tick = 1'b1;
        cyc();
        period_tick = 1'b0;
        chk("pass_start_state", loop_state, 2);
    endtask

    task automatic run_beams(input int drain_beam, input int tick_beam);
        for (int b = 0; b < NB; b++) begin
            longint unsigned exp_thr;
            int n;
            n = 0;
            while (scal_req !== 1'b1 && n < 20) begin
                cyc();
                n++;
            end
            if (scal_req !== 1'b1) begin
                chk("scal_req_timeout", scal_req, 1);
                return;
            end
            chk("scal_idx", scal_idx, b);
            chk("no_update_mid_pass", thresh_update, 0);
            repeat ($urandom_range(0, 2)) begin
                cyc();
                chk("scal_req_held", scal_req, 1);
            end
            scal_valid = 1'b1;
            scal_dat   = SBW'(cnt_tab[b]);
            cyc();
            scal_valid = 1'b0;
            scal_dat   = SBW'($urandom);
            chk("scal_req_drop", scal_req, 0);
            chk("wr_not_early", thresh_wr, 0);
            cyc();
            exp_thr = model_next(model_thr[b], cnt_tab[b]);
            chk("wr_rise", thresh_wr, 1);
            chk("wr_idx", thresh_idx, b);
            chk("wr_dat", thresh_dat, exp_thr);
            if (b == drain_beam) loop_enable = 1'b0;
            for (int k = 0; k < int'(ackd_tab[b]); k++) begin
                if (b == tick_beam && k == 0) period_tick = 1'b1;
                cyc();
                period_tick = 1'b0;
                chk("wr_held", thresh_wr, 1);
                chk("wr_idx_held", thresh_idx, b);
                chk("wr_dat_held", thresh_dat, exp_thr);
                if (b == drain_beam) chk("drain_state", loop_state, 3);
            end
            thresh_ack = 1'b1;
            rd_idx     = 6'(b);
            cyc();
            thresh_ack = 1'b0;
            chk("rd_old_on_update", rd_dat, model_thr[b]);
            model_thr[b] = exp_thr;
            chk("wr_drop", thresh_wr, 0);
            if (b == drain_beam) begin
                chk("drain_stopped", loop_state, 0);
                repeat (4) begin
                    cyc();
                    chk("drain_no_req", scal_req, 0);
                    chk("drain_no_update", thresh_update, 0);
                end
                return;
            end
        end
        chk("update_pulse", thresh_update, 1);
        chk("back_to_waiting", loop_state, 1);
        cyc();
        chk("update_single", thresh_update, 0);
    endtask

    task automatic fill_random(input int unsigned max_cnt);
        for (int i = 0; i < NB; i++) begin
            cnt_tab[i]  = $urandom_range(0, max_cnt);
            ackd_tab[i] = $urandom_range(0, 3);
        end
    endtask

    initial begin
        rst = 1'b1; loop_enable = 1'b0; period_tick = 1'b0;
        target_rate = 24'd100; target_delta = 24'd5; step = 12'd50;
        scal_dat = '0; scal_valid = 1'b0; thresh_ack = 1'b0;
        init_wr = 1'b0; init_idx = '0; init_dat = '0; rd_idx = '0;
        for (int i = 0; i < NB; i++) model_thr[i] = 4500;
        repeat (3) cyc();
        chk("rst_state", loop_state, 0);
        chk("rst_scal_req", scal_req, 0);
        chk("rst_wr", thresh_wr, 0);
        chk("rst_update", thresh_update, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_rd_dat", rd_dat, 0);
        chk("rst_scal_idx", scal_idx, 0);
        chk("rst_thresh_idx", thresh_idx, 0);
        rst = 1'b0;
        cyc();
        chk("rd_start_thresh", rd_dat, 4500);
        loop_enable = 1'b1;
        cyc();
        chk("enable_waiting", loop_state, 1);

        // Pass 1: everything in band, thresholds unchanged.
        for (int i = 0; i < NB; i++) begin cnt_tab[i] = 100; ackd_tab[i] = $urandom_range(0, 3); end
        start_pass();
        run_beams(-1, -1);

        // Pass 2: directed up/down beams, band edges, overrun tick mid-pass.
        fill_random(300);
        cnt_tab[3] = 200; cnt_tab[4] = 10;
        cnt_tab[6] = 105; cnt_tab[7] = 95; cnt_tab[8] = 106; cnt_tab[9] = 94;
        ackd_tab[5] = 3;
        start_pass();
        run_beams(-1, 5);
        chk("overrun_set", overrun, 1);
        repeat (5) begin
            cyc();
            chk("no_second_pass_req", scal_req, 0);
            chk("no_second_pass_state", loop_state, 1);
        end
        rd_idx = 6'd3;
        cyc();
        chk("rd_beam3", rd_dat, model_thr[3]);

        // Pass 3: small step, one far-out beam (coarse step when enabled).
        step = 12'd10;
        for (int i = 0; i < NB; i++) begin cnt_tab[i] = 100; ackd_tab[i] = $urandom_range(0, 3); end
        cnt_tab[5] = 200;
        start_pass();
        run_beams(-1, -1);

        // Preload is ignored outside STOPPED, honoured in STOPPED, and clears overrun.
        init_wr = 1'b1; init_idx = 6'd2; init_dat = 18'd777;
        cyc();
        init_wr = 1'b0; rd_idx = 6'd2;
        cyc();
        chk("init_ignored_waiting", rd_dat, model_thr[2]);
        loop_enable = 1'b0;
        cyc();
        chk("disable_stopped", loop_state, 0);
        init_wr = 1'b1; init_idx = 6'd0; init_dat = TBW'(TMAX - 10);
        cyc();
        init_idx = 6'd1; init_dat = 18'd20;
        cyc();
        init_idx = 6'd50; init_dat = 18'd5;
        cyc();
        init_wr = 1'b0; rd_idx = 6'd0;
        model_thr[0] = TMAX - 10; model_thr[1] = 20;
        cyc();
        chk("overrun_cleared", overrun, 0);
        chk("rd_preload0", rd_dat, TMAX - 10);
        rd_idx = 6'd1;
        cyc();
        chk("rd_preload1", rd_dat, 20);

        // Pass 4: saturation at both limits.
        loop_enable = 1'b1;
        cyc();
        step = 12'd50;
        fill_random(300);
        cnt_tab[0] = 1000; cnt_tab[1] = 0;
        start_pass();
        run_beams(-1, -1);
        rd_idx = 6'd0;
        cyc();
        chk("rd_sat_hi", rd_dat, TMAX);
        rd_idx = 6'd1;
        cyc();
        chk("rd_sat_lo", rd_dat, 0);

        // Pass 5: delta > target clamps lo at 0; enable drops during a slow ack on beam 10.
        target_rate = 24'd3; target_delta = 24'd10;
        fill_random(40);
        cnt_tab[0] = 0;
        ackd_tab[10] = 7;
        start_pass();
        run_beams(10, -1);
        loop_enable = 1'b1;
        cyc();
        chk("reenable_waiting", loop_state, 1);

        // Pass 6: a fresh pass restarts at beam 0.
        target_rate = 24'd100; target_delta = 24'd5;
        fill_random(300);
        start_pass();
        run_beams(-1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
